writeback_unit: RTL and testbench

//  Write-side companion to the 32x32 register file. Merges ALU results and load returns

---
 rtl/writeback_unit_if.sv | 36 +++
 rtl/writeback_unit.sv | 97 +++++++++
 tb/tb_writeback_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Bundles the write-back unit's ALU, load, decode and register-file signals into one port.
// The master modport is the surrounding pipeline; the slave modport is the unit itself.
interface writeback_unit_if #(
  parameter int DWIDTH = 32
);
  logic              alu_valid_i;
  logic [4:0]        alu_rd_i;
  logic [DWIDTH-1:0] alu_data_i;
  logic              alu_ready_o;
  logic              ld_issue_i;
  logic [4:0]        ld_issue_rd_i;
  logic              ld_valid_i;
  logic [4:0]        ld_rd_i;
  logic [DWIDTH-1:0] ld_data_i;
  logic [2:0]        ld_funct3_i;
  logic [1:0]        ld_offset_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [4:0]        rd_o;
  logic [DWIDTH-1:0] datawb_o;
  logic              regwren_o;
  logic [31:0]       busy_o;
  logic              stall_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i, ld_issue_i, ld_issue_rd_i,
           ld_valid_i, ld_rd_i, ld_data_i, ld_funct3_i, ld_offset_i, rs1_i, rs2_i,
    input  alu_ready_o, rd_o, datawb_o, regwren_o, busy_o, stall_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i, ld_issue_i, ld_issue_rd_i,
           ld_valid_i, ld_rd_i, ld_data_i, ld_funct3_i, ld_offset_i, rs1_i, rs2_i,
    output alu_ready_o, rd_o, datawb_o, regwren_o, busy_o, stall_o
  );
endinterface

// File: rtl/writeback_unit.sv
// Merges ALU results and extended load returns onto the register-file write port, latency 1.
// Loads always win; the ALU is held off (ready low) while a load returns; pending loads stall decode.
module writeback_unit #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  writeback_unit_if.slave   wb
);

  logic              w_ld_acc;
  logic              w_alu_acc;
  logic              w_any_acc;
  logic [4:0]        w_acc_rd;
  logic [DWIDTH-1:0] w_acc_data;
  logic [DWIDTH-1:0] w_ld_ext;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_set;
  logic [31:0]       w_clr;
  logic              w_hz1;
  logic              w_hz2;

  logic              r_wren;
  logic [4:0]        r_rd;
  logic [DWIDTH-1:0] r_data;
  logic [31:0]       r_busy;

  assign w_ld_acc       = wb.ld_valid_i;
  assign w_alu_acc      = wb.alu_valid_i & ~wb.ld_valid_i;
  assign w_any_acc      = w_ld_acc | w_alu_acc;
  assign w_acc_rd       = w_ld_acc ? wb.ld_rd_i : wb.alu_rd_i;
  assign w_acc_data     = w_ld_acc ? w_ld_ext : wb.alu_data_i;
  assign wb.alu_ready_o = ~wb.ld_valid_i;

  always_comb begin
    w_byte = wb.ld_data_i[7:0];
    case (wb.ld_offset_i)
      2'd1:    w_byte = wb.ld_data_i[15:8];
      2'd2:    w_byte = wb.ld_data_i[23:16];
      2'd3:    w_byte = wb.ld_data_i[31:24];
      default: w_byte = wb.ld_data_i[7:0];
    endcase
  end

  // Halfword lane uses only address bit 1; bit 0 is ignored.
  assign w_half = wb.ld_offset_i[1] ? wb.ld_data_i[31:16] : wb.ld_data_i[15:0];

  always_comb begin
    w_ld_ext = wb.ld_data_i;
    case (wb.ld_funct3_i)
      3'b000:  w_ld_ext = {{(DWIDTH-8){w_byte[7]}}, w_byte};
      3'b100:  w_ld_ext = {{(DWIDTH-8){1'b0}}, w_byte};
      3'b001:  w_ld_ext = {{(DWIDTH-16){w_half[15]}}, w_half};
      3'b101:  w_ld_ext = {{(DWIDTH-16){1'b0}}, w_half};
      default: w_ld_ext = wb.ld_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wren <= 1'b0;
      r_rd   <= 5'd0;
      r_data <= '0;
    end else begin
      r_wren <= w_any_acc & (w_acc_rd != 5'd0);
      if (w_any_acc) begin
        r_rd   <= w_acc_rd;
        r_data <= w_acc_data;
      end
    end
  end

  // Set is OR-ed after clear so a same-cycle issue to the same rd keeps the bit.
  assign w_set = (wb.ld_issue_i && wb.ld_issue_rd_i != 5'd0) ? (32'd1 << wb.ld_issue_rd_i) : 32'd0;
  assign w_clr = wb.ld_valid_i ? (32'd1 << wb.ld_rd_i) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end
  end

  assign w_hz1 = (wb.rs1_i != 5'd0) &
                 (r_busy[wb.rs1_i] | (r_wren & (r_rd == wb.rs1_i)) | (w_any_acc & (w_acc_rd == wb.rs1_i)));
  assign w_hz2 = (wb.rs2_i != 5'd0) &
                 (r_busy[wb.rs2_i] | (r_wren & (r_rd == wb.rs2_i)) | (w_any_acc & (w_acc_rd == wb.rs2_i)));

  assign wb.stall_o   = w_hz1 | w_hz2;
  assign wb.rd_o      = r_rd;
  assign wb.datawb_o  = r_data;
  assign wb.regwren_o = r_wren;
  assign wb.busy_o    = r_busy;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus a queue of expected register-file writes.
module tb_writeback_unit;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_unit_if #(.DWIDTH(32)) bus();
  writeback_unit #(.DWIDTH(32)) dut (.clk(clk), .rst(rst), .wb(bus));

  wr_t         exp_q[$];
  wr_t         mon_got;
  wr_t         mon_exp;
  logic [31:0] rf [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Register file model: commits on the edge after the write appears.
  always @(posedge clk) begin
    if (bus.regwren_o === 1'b1 && bus.rd_o != 5'd0) rf[bus.rd_o] <= bus.datawb_o;
  end

  // Scoreboard: every visible write must match the next expected one, in order.
  always @(negedge clk) begin
    if (bus.regwren_o === 1'b1) begin
      mon_got = '{rd: bus.rd_o, data: bus.datawb_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write", mon_got.rd, mon_got.data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL wb_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   mon_got.rd, mon_got.data, mon_exp.rd, mon_exp.data);
        end
      end
    end
  end

  function automatic logic [31:0] ext_model(input logic [2:0] f, input logic [1:0] off, input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (off[1] ? (d >> 16) : d) & 32'hFFFF;
    case (f)
      3'b000:  return (b ^ 32'h80) - 32'h80;
      3'b100:  return b;
      3'b001:  return (h ^ 32'h8000) - 32'h8000;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid_i   = 1'b0;
    bus.alu_rd_i      = 5'd0;
    bus.alu_data_i    = 32'd0;
    bus.ld_issue_i    = 1'b0;
    bus.ld_issue_rd_i = 5'd0;
    bus.ld_valid_i    = 1'b0;
    bus.ld_rd_i       = 5'd0;
    bus.ld_data_i     = 32'd0;
    bus.ld_funct3_i   = 3'd0;
    bus.ld_offset_i   = 2'd0;
  endtask

  task automatic load_ret(input logic [4:0] rd, input logic [2:0] f, input logic [1:0] off, input logic [31:0] d);
    bus.ld_valid_i  = 1'b1;
    bus.ld_rd_i     = rd;
    bus.ld_funct3_i = f;
    bus.ld_offset_i = off;
    bus.ld_data_i   = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rs1_i = 5'd2;
    bus.rs2_i = 5'd2;
    bus.ld_issue_i = 1'b1;
    bus.ld_issue_rd_i = 5'd3;
    load_ret(5'd3, 3'b010, 2'd0, 32'h5);
    step();
    step();
    n_checks++;
    if ({bus.regwren_o, bus.rd_o, bus.datawb_o} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_out: got wren=%b rd=%0d data=%h, required 0/0/0", bus.regwren_o, bus.rd_o, bus.datawb_o);
    end
    n_checks++;
    if (bus.busy_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_busy: got %h, required 0", bus.busy_o);
    end
    rst = 1'b0;
    idle();
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b, required 0", bus.stall_o);
    end
    step();
    n_checks++;
    if (bus.busy_o !== 32'd0 || bus.regwren_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ignored: got busy=%h wren=%b, required 0/0", bus.busy_o, bus.regwren_o);
    end
  endtask

  task automatic test_alu();
    bus.rs1_i = 5'd5;
    bus.rs2_i = 5'd0;
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd5;
    bus.alu_data_i  = 32'h1234;
    exp_q.push_back('{rd: 5'd5, data: 32'h1234});
    #1;
    n_checks++;
    if ({bus.alu_ready_o, bus.stall_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL alu_accept: got ready=%b stall=%b, required 1/1", bus.alu_ready_o, bus.stall_o);
    end
    step();
    bus.alu_valid_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.regwren_o, bus.rd_o, bus.datawb_o, bus.stall_o} !== {1'b1, 5'd5, 32'h1234, 1'b1}) begin
      n_fail++;
      $display("FAIL alu_out: got wren=%b rd=%0d data=%h stall=%b, required 1/5/00001234/1",
               bus.regwren_o, bus.rd_o, bus.datawb_o, bus.stall_o);
    end
    step();
    n_checks++;
    if (rf[5] !== 32'h1234 || bus.regwren_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.rd_o !== 5'd5) begin
      n_fail++;
      $display("FAIL alu_commit: got x5=%h wren=%b stall=%b rd=%0d, required 00001234/0/0/5",
               rf[5], bus.regwren_o, bus.stall_o, bus.rd_o);
    end
  endtask

  task automatic test_load_sign();
    bus.rs1_i = 5'd7;
    bus.ld_issue_i = 1'b1;
    bus.ld_issue_rd_i = 5'd7;
    #1;
    n_checks++;
    if (bus.stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_issue_stall: got %b, required 0", bus.stall_o);
    end
    step();
    idle();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.busy_o[7] !== 1'b1 || bus.stall_o !== 1'b1) begin
        n_fail++;
        $display("FAIL ld_pending: cycle %0d got busy7=%b stall=%b, required 1/1", i, bus.busy_o[7], bus.stall_o);
      end
      step();
    end
    load_ret(5'd7, 3'b000, 2'd3, 32'h80FF_7F01);
    exp_q.push_back('{rd: 5'd7, data: 32'hFFFF_FF80});
    step();
    idle();
    #1;
    n_checks++;
    if ({bus.busy_o[7], bus.stall_o, bus.datawb_o} !== {1'b0, 1'b1, 32'hFFFF_FF80}) begin
      n_fail++;
      $display("FAIL ld_return: got busy7=%b stall=%b data=%h, required 0/1/ffffff80",
               bus.busy_o[7], bus.stall_o, bus.datawb_o);
    end
    step();
    n_checks++;
    if (bus.stall_o !== 1'b0 || rf[7] !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL ld_commit: got stall=%b x7=%h, required 0/ffffff80", bus.stall_o, rf[7]);
    end
  endtask

  task automatic test_arbitration();
    bus.rs1_i = 5'd0;
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd10;
    bus.alu_data_i  = 32'hA5A5_0001;
    load_ret(5'd11, 3'b010, 2'd1, 32'h1111_2222);
    exp_q.push_back('{rd: 5'd11, data: 32'h1111_2222});
    #1;
    n_checks++;
    if (bus.alu_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_ready_low: got %b, required 0", bus.alu_ready_o);
    end
    step();
    bus.ld_valid_i = 1'b0;
    exp_q.push_back('{rd: 5'd10, data: 32'hA5A5_0001});
    #1;
    n_checks++;
    if (bus.alu_ready_o !== 1'b1 || bus.rd_o !== 5'd11) begin
      n_fail++;
      $display("FAIL arb_load_first: got ready=%b rd=%0d, required 1/11", bus.alu_ready_o, bus.rd_o);
    end
    step();
    idle();
    n_checks++;
    if (bus.rd_o !== 5'd10 || bus.datawb_o !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL arb_alu_second: got rd=%0d data=%h, required 10/a5a50001", bus.rd_o, bus.datawb_o);
    end
  endtask

  task automatic test_lhu_x0();
    load_ret(5'd12, 3'b101, 2'd2, 32'hBEEF_0000);
    exp_q.push_back('{rd: 5'd12, data: 32'h0000_BEEF});
    step();
    idle();
    n_checks++;
    if (bus.datawb_o !== 32'h0000_BEEF) begin
      n_fail++;
      $display("FAIL lhu_ext: got %h, required 0000beef", bus.datawb_o);
    end
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd0;
    bus.alu_data_i  = 32'hDEAD;
    #1;
    n_checks++;
    if (bus.alu_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_ready: got %b, required 1", bus.alu_ready_o);
    end
    step();
    idle();
    n_checks++;
    if (bus.regwren_o !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_wren: got %b, required 0", bus.regwren_o);
    end
  endtask

  task automatic test_set_clear();
    bus.ld_issue_i = 1'b1;
    bus.ld_issue_rd_i = 5'd14;
    load_ret(5'd14, 3'b010, 2'd0, 32'h0000_000E);
    exp_q.push_back('{rd: 5'd14, data: 32'h0000_000E});
    step();
    idle();
    bus.ld_issue_i = 1'b1;
    bus.ld_issue_rd_i = 5'd0;
    n_checks++;
    if (bus.busy_o !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL set_wins: got busy=%h, required 00004000", bus.busy_o);
    end
    step();
    idle();
    n_checks++;
    if (bus.busy_o !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL busy_x0: got busy=%h, required 00004000", bus.busy_o);
    end
    load_ret(5'd14, 3'b010, 2'd0, 32'h0000_0077);
    exp_q.push_back('{rd: 5'd14, data: 32'h0000_0077});
    step();
    idle();
    n_checks++;
    if (bus.busy_o !== 32'd0) begin
      n_fail++;
      $display("FAIL busy_clear: got busy=%h, required 0", bus.busy_o);
    end
  endtask

  task automatic test_reset_inflight();
    bus.ld_issue_i = 1'b1;
    bus.ld_issue_rd_i = 5'd9;
    step();
    idle();
    n_checks++;
    if (bus.busy_o !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL pre_reset_busy: got %h, required 00000200", bus.busy_o);
    end
    rst = 1'b1;
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd13;
    bus.alu_data_i  = 32'hDEAD_BEEF;
    step();
    rst = 1'b0;
    idle();
    n_checks++;
    if (bus.regwren_o !== 1'b0 || bus.busy_o !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got wren=%b busy=%h, required 0/0", bus.regwren_o, bus.busy_o);
    end
    load_ret(5'd9, 3'b010, 2'd0, 32'h9999_0009);
    exp_q.push_back('{rd: 5'd9, data: 32'h9999_0009});
    step();
    idle();
    n_checks++;
    if ({bus.regwren_o, bus.rd_o} !== {1'b1, 5'd9} || bus.busy_o !== 32'd0) begin
      n_fail++;
      $display("FAIL stray_return: got wren=%b rd=%0d busy=%h, required 1/9/0", bus.regwren_o, bus.rd_o, bus.busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rd;
    logic [2:0]  f;
    logic [1:0]  off;
    logic [31:0] d;
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd20;
    bus.alu_data_i  = 32'h5555_AAAA;
    for (int i = 0; i < 24; i++) begin
      rd  = 5'($urandom_range(1, 31));
      f   = 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      d   = $urandom;
      load_ret(rd, f, off, d);
      exp_q.push_back('{rd: rd, data: ext_model(f, off, d)});
      #1;
      n_checks++;
      if (bus.alu_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_alu_held: iter %0d got ready=%b, required 0", i, bus.alu_ready_o);
      end
      step();
    end
    bus.ld_valid_i = 1'b0;
    exp_q.push_back('{rd: 5'd20, data: 32'h5555_AAAA});
    step();
    idle();
    step();
    step();
    n_checks++;
    if (bus.busy_o !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_busy: got %h, required 0", bus.busy_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    idle();
    test_reset();
    test_alu();
    test_load_sign();
    test_arbitration();
    test_lhu_x0();
    test_set_clear();
    test_reset_inflight();
    test_back_to_back();
    step();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
